// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if -- data-memory request/response bus between the MEM/WB stage
// and the data memory.
//   mem_req   : request valid (held until mem_ack or timeout)
//   mem_we    : write qualifier for the request
//   mem_addr  : request address
//   mem_wdata : store data
//   mem_ack   : memory completion
//   mem_rdata : load data, valid with mem_ack
// The master modport is the pipeline stage; the slave modport is the memory.
interface mem_wb_stage_if #(
   parameter int DBITS = 32
);
   logic             mem_req;
   logic             mem_we;
   logic [DBITS-1:0] mem_addr;
   logic [DBITS-1:0] mem_wdata;
   logic             mem_ack;
   logic [DBITS-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage -- combined memory-access and write-back pipeline stage.
// Non-memory instructions write the register file combinationally with zero
// latency. Loads and stores capture their operands, stall upstream, issue a
// request on the memory bus and write back one cycle after mem_ack (or report
// mem_err if no ack arrives within TIMEOUT_CYCLES request cycles).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid + *_in     : stage-2 instruction from the pipeline register
//   mem (master)        : data-memory request/response bus
//   stall               : upstream pipeline register holds while high
//   rf_wrtEn/Index/Data : register-file write port
//   mem_err             : one-cycle pulse on memory timeout
module mem_wb_stage #(
   parameter int DBITS               = 32,
   parameter int REG_INDEX_BIT_WIDTH = 4,
   parameter int TIMEOUT_CYCLES      = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   input  logic [DBITS-1:0]               dmemAddr_in,
   input  logic [DBITS-1:0]               dmemDataIn_in,
   input  logic [DBITS-1:0]               PCinc_in,
   input  logic [DBITS-1:0]               regFileAluOut_in,
   input  logic                           dmemWrtEn_in,
   input  logic                           memtoReg_in,
   input  logic                           jal_in,
   input  logic                           regFileWrtEn_in,
   input  logic [REG_INDEX_BIT_WIDTH-1:0] regWrtIndex_in,
   mem_wb_stage_if.master                 mem,
   output logic                           stall,
   output logic                           rf_wrtEn,
   output logic [REG_INDEX_BIT_WIDTH-1:0] rf_wrtIndex,
   output logic [DBITS-1:0]               rf_wrtData,
   output logic                           mem_err
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_RESP   = 2'd2;

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   // Counter value on the last permitted request cycle.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [1:0]                     state_q, state_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           timeout_q, timeout_d;
   logic [DBITS-1:0]               addr_q, addr_d;
   logic [DBITS-1:0]               wdata_q, wdata_d;
   logic [DBITS-1:0]               alu_q, alu_d;
   logic [DBITS-1:0]               pcinc_q, pcinc_d;
   logic [DBITS-1:0]               rdata_q, rdata_d;
   logic                           we_q, we_d;
   logic                           load_q, load_d;
   logic                           jal_q, jal_d;
   logic                           wen_q, wen_d;
   logic [REG_INDEX_BIT_WIDTH-1:0] idx_q, idx_d;

   logic mem_op;
   assign mem_op = in_valid & (dmemWrtEn_in | memtoReg_in);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      alu_d     = alu_q;
      pcinc_d   = pcinc_q;
      rdata_d   = rdata_q;
      we_d      = we_q;
      load_d    = load_q;
      jal_d     = jal_q;
      wen_d     = wen_q;
      idx_d     = idx_q;
      case (state_q)
         S_IDLE: begin
            if (mem_op) begin
               addr_d    = dmemAddr_in;
               wdata_d   = dmemDataIn_in;
               alu_d     = regFileAluOut_in;
               pcinc_d   = PCinc_in;
               we_d      = dmemWrtEn_in;
               // Store wins when both flags are set: never write back memory data.
               load_d    = memtoReg_in & ~dmemWrtEn_in;
               jal_d     = jal_in;
               wen_d     = regFileWrtEn_in;
               idx_d     = regWrtIndex_in;
               cnt_d     = '0;
               timeout_d = 1'b0;
               state_d   = S_ACCESS;
            end
         end
         S_ACCESS: begin
            cnt_d = cnt_q + CNT_W'(1);
            // An ack on the limit cycle takes priority over the timeout.
            if (mem.mem_ack) begin
               rdata_d = mem.mem_rdata;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               timeout_d = 1'b1;
               state_d   = S_RESP;
            end
         end
         S_RESP: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         alu_q     <= '0;
         pcinc_q   <= '0;
         rdata_q   <= '0;
         we_q      <= 1'b0;
         load_q    <= 1'b0;
         jal_q     <= 1'b0;
         wen_q     <= 1'b0;
         idx_q     <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         alu_q     <= alu_d;
         pcinc_q   <= pcinc_d;
         rdata_q   <= rdata_d;
         we_q      <= we_d;
         load_q    <= load_d;
         jal_q     <= jal_d;
         wen_q     <= wen_d;
         idx_q     <= idx_d;
      end
   end

   assign mem.mem_req   = (state_q == S_ACCESS);
   assign mem.mem_we    = (state_q == S_ACCESS) & we_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   always_comb begin
      stall       = 1'b0;
      rf_wrtEn    = 1'b0;
      rf_wrtIndex = idx_q;
      rf_wrtData  = alu_q;
      mem_err     = 1'b0;
      case (state_q)
         S_IDLE: begin
            stall       = mem_op;
            rf_wrtEn    = in_valid & regFileWrtEn_in & ~mem_op;
            rf_wrtIndex = regWrtIndex_in;
            rf_wrtData  = jal_in ? PCinc_in : regFileAluOut_in;
         end
         S_ACCESS: stall = 1'b1;
         S_RESP: begin
            rf_wrtEn   = wen_q & ~timeout_q;
            rf_wrtData = jal_q ? pcinc_q : (load_q ? rdata_q : alu_q);
            mem_err    = timeout_q;
         end
         default: ;
      endcase
   end

endmodule
